bram_controller: RTL and testbench

BRAM_CONTROLLER -- requirements
Module: bram_controller

---
 rtl/bram_controller_pkg.sv | 13 +
 rtl/bram_sp.sv | 47 ++++
 rtl/bram_controller.sv | 96 +++++++++
 tb/tb_bram_controller.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bram_controller_pkg.sv
// rtl/bram_controller_pkg.sv - shared types and widths for the BRAM controller
package bram_controller_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/bram_sp.sv
// rtl/bram_sp.sv - single-port synchronous BRAM with byte write enables
module bram_sp
  import bram_controller_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int INIT_INDEX = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [STRB_W-1:0] we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  // Power-up image: either word[i] = i or all zero. It lives in the
  // declaration so it is part of the configuration, not of reset.
  function automatic logic [DEPTH-1:0][WORD_W-1:0] init_image();
    logic [DEPTH-1:0][WORD_W-1:0] img;
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = (INIT_INDEX != 0) ? WORD_W'(i) : '0;
    end
    return img;
  endfunction

  logic [DEPTH-1:0][WORD_W-1:0] mem_q = init_image();
  logic [WORD_W-1:0]            dout_q;

  // Write-first per byte: written lanes return the new byte, others the stored byte,
  // so a write access yields the merged word on dout.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (we[b]) begin
          mem_q[addr][8*b +: 8] <= din[8*b +: 8];
          dout_q[8*b +: 8]      <= din[8*b +: 8];
        end else begin
          dout_q[8*b +: 8]      <= mem_q[addr][8*b +: 8];
        end
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/bram_controller.sv
// rtl/bram_controller.sv - three-state request/response wrapper around bram_sp
module bram_controller
  import bram_controller_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int INIT_INDEX = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata
);

  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              ready_q, ready_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [WORD_W-1:0] bram_dout;

  // Byte-offset bits and bits above the word index never matter: indices wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

  // Next-state logic: capture the request in IDLE, access once, respond once.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          state_d = ACCESS;
          idx_d   = mem_addr[AW+1:2];
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
        end
      end
      ACCESS: begin
        state_d = RESP;
        ready_d = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = bram_dout;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured request and response registers; reset leaves memory alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  bram_sp #(
    .DEPTH      (DEPTH),
    .INIT_INDEX (INIT_INDEX)
  ) u_bram (
    .clk  (clk),
    .en   (state_q == ACCESS),
    .we   (wstrb_q),
    .addr (idx_q),
    .din  (wdata_q),
    .dout (bram_dout)
  );

  // During RESP the BRAM output is the answer; afterwards the held copy is shown.
  assign mem_ready = ready_q;
  assign mem_rdata = ready_q ? bram_dout : rdata_q;

endmodule

// File: tb/tb_bram_controller.sv
// tb/tb_bram_controller.sv - table-driven scoreboard bench for bram_controller
module tb_bram_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  bram_controller #(.DEPTH(256), .INIT_INDEX(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] sb_q[$];
  vec_t        vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      check({name, " unexpected response"}, mem_rdata, 32'hxxxxxxxx);
    end else begin
      e = sb_q.pop_front();
      check(name, mem_rdata, e);
    end
  endtask

  // One request from an idle controller; inputs are scrambled after acceptance.
  task automatic do_req(input string name, input logic [31:0] a, input logic [31:0] w,
                        input logic [3:0] s, input logic [31:0] e);
    int lat;
    lat = 0;
    @(negedge clk);
    mem_addr = a; mem_wdata = w; mem_wstrb = s; mem_valid = 1'b1;
    @(posedge clk);
    sb_q.push_back(e);
    #1;
    mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_ready) begin
        lat = c;
        pop_check({name, " rdata"});
        mem_valid = 1'b0;
      end
    end
    check({name, " latency"}, 32'(lat), 32'd2);
    if (lat == 0) begin
      mem_valid = 1'b0;
      sb_q.delete();
    end
    @(negedge clk);
    check({name, " ready pulse"}, {31'd0, mem_ready}, 32'd0);
    check({name, " rdata hold"}, mem_rdata, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1;
    int r2;
    int seen;

    vecs[0]  = '{32'h0000_0010, 32'h0,         4'b0000, 32'h0000_0004};
    vecs[1]  = '{32'h0000_0020, 32'h0,         4'b0000, 32'h0000_0008};
    vecs[2]  = '{32'h0000_0010, 32'h0000_FFFF, 4'b1111, 32'h0000_FFFF};
    vecs[3]  = '{32'h0000_0020, 32'h0000_FF00, 4'b1111, 32'h0000_FF00};
    vecs[4]  = '{32'h0000_0010, 32'h0,         4'b0000, 32'h0000_FFFF};
    vecs[5]  = '{32'h0000_0020, 32'h0,         4'b0000, 32'h0000_FF00};
    vecs[6]  = '{32'h0000_0030, 32'hAABB_CCDD, 4'b0101, 32'h00BB_00DD};
    vecs[7]  = '{32'h0000_0030, 32'h0,         4'b0000, 32'h00BB_00DD};
    vecs[8]  = '{32'h0000_0400, 32'h0,         4'b0000, 32'h0000_0000};
    vecs[9]  = '{32'h0000_0013, 32'h0,         4'b0000, 32'h0000_FFFF};
    vecs[10] = '{32'hFFFF_FC08, 32'h0,         4'b0000, 32'h0000_0002};
    vecs[11] = '{32'h0000_03FC, 32'h1122_3344, 4'b1000, 32'h1100_00FF};
    vecs[12] = '{32'h0000_07FC, 32'h0,         4'b0000, 32'h1100_00FF};
    vecs[13] = '{32'h0000_0005, 32'h5566_7788, 4'b0010, 32'h0000_7701};

    reset_n = 1'b0; mem_valid = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (3) @(negedge clk);
    check("reset ready", {31'd0, mem_ready}, 32'd0);
    check("reset rdata", mem_rdata, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp);
    end

    // Valid held through RESP: the next request is accepted right after, 3 cycles apart.
    r1 = 0; r2 = 0;
    @(negedge clk);
    mem_addr = 32'h20; mem_wstrb = 4'b0000; mem_valid = 1'b1;
    @(posedge clk);
    sb_q.push_back(32'h0000_FF00);
    for (int k = 1; k <= 12 && r2 == 0; k++) begin
      @(negedge clk);
      if (mem_ready) begin
        if (r1 == 0) begin
          r1 = k;
          pop_check("b2b first rdata");
          mem_addr = 32'h10;
          sb_q.push_back(32'h0000_FFFF);
        end else begin
          r2 = k;
          pop_check("b2b second rdata");
          mem_valid = 1'b0;
        end
      end
    end
    mem_valid = 1'b0;
    check("b2b first latency", 32'(r1), 32'd2);
    check("b2b second latency", 32'(r2), 32'd5);
    sb_q.delete();
    @(negedge clk);

    // Reset during ACCESS of a write: the write is dropped and no response follows.
    @(negedge clk);
    mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'b1111; mem_valid = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    mem_valid = 1'b0;
    #1;
    check("async reset ready", {31'd0, mem_ready}, 32'd0);
    check("async reset rdata", mem_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_ready) seen++;
    end
    check("no response after reset", 32'(seen), 32'd0);
    do_req("post-reset read 0x40", 32'h40, 32'h0, 4'b0000, 32'h0000_0010);

    check("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
